// File: rtl/vga_timing_dither_if.sv
// Lab-side pixel bus plus VGA pin bundle; master is the timing generator.
// No handshake: the lab side must answer x/y combinationally; no backpressure.
interface vga_timing_dither_if #(
  parameter int w_x         = 10,
  parameter int w_y         = 10,
  parameter int w_color_in  = 4,
  parameter int w_color_out = 1
);
  logic [w_x-1:0]         x;
  logic [w_y-1:0]         y;
  logic                   pixel_en;
  logic                   frame_start;
  logic [w_color_in-1:0]  red_in;
  logic [w_color_in-1:0]  green_in;
  logic [w_color_in-1:0]  blue_in;
  logic                   vga_hsync;
  logic                   vga_vsync;
  logic                   vga_display_on;
  logic [w_color_out-1:0] vga_red;
  logic [w_color_out-1:0] vga_green;
  logic [w_color_out-1:0] vga_blue;

  modport master (
    output x, y, pixel_en, frame_start,
    output vga_hsync, vga_vsync, vga_display_on, vga_red, vga_green, vga_blue,
    input  red_in, green_in, blue_in
  );

  modport slave (
    input  x, y, pixel_en, frame_start,
    input  vga_hsync, vga_vsync, vga_display_on, vga_red, vga_green, vga_blue,
    output red_in, green_in, blue_in
  );
endinterface

// File: rtl/vga_timing_dither.sv
// VGA timing generator with 2x2 ordered-dither colour reduction; pins lag x/y by
// one pixel period. Free-running, no backpressure.
module vga_timing_dither #(
  parameter int clk_mhz          = 50,
  parameter int pixel_mhz        = 25,
  parameter int h_active         = 640,
  parameter int h_front          = 16,
  parameter int h_sync           = 96,
  parameter int h_back           = 48,
  parameter int v_active         = 480,
  parameter int v_front          = 10,
  parameter int v_sync           = 2,
  parameter int v_back           = 33,
  parameter int sync_active_high = 0,
  parameter int w_color_in       = 4,
  parameter int w_color_out      = 1,
  parameter int w_x              = $clog2(h_active + h_front + h_sync + h_back),
  parameter int w_y              = $clog2(v_active + v_front + v_sync + v_back)
) (
  input  logic                clk,
  input  logic                rst,
  vga_timing_dither_if.master bus
);

  localparam int h_total = h_active + h_front + h_sync + h_back;
  localparam int v_total = v_active + v_front + v_sync + v_back;
  localparam int div     = clk_mhz / pixel_mhz;
  localparam int w_div   = (div > 1) ? $clog2(div) : 1;
  localparam int shift   = w_color_in - w_color_out;
  localparam int hs_lo   = h_active + h_front;
  localparam int hs_hi   = h_active + h_front + h_sync;
  localparam int vs_lo   = v_active + v_front;
  localparam int vs_hi   = v_active + v_front + v_sync;
  // XOR mask for the sync pins; also equals their idle level.
  localparam logic sync_inv = (sync_active_high == 0);

  logic                   pix_en_q;
  logic [w_x-1:0]         hpos;
  logic [w_y-1:0]         vpos;
  logic [31:0]            hpos_w;
  logic [31:0]            vpos_w;
  logic                   h_last;
  logic                   v_last;
  logic                   act0;
  logic                   hs0;
  logic                   vs0;
  logic                   hsync_q;
  logic                   vsync_q;
  logic                   display_on_q;
  logic [w_color_out-1:0] red_q;
  logic [w_color_out-1:0] green_q;
  logic [w_color_out-1:0] blue_q;

  // Strobe is registered, so it rises div clks after reset release.
  generate
    if (div <= 1) begin : g_div_one
      always_ff @(posedge clk) begin
        if (rst) pix_en_q <= 1'b0;
        else     pix_en_q <= 1'b1;
      end
    end else begin : g_div_n
      logic [w_div-1:0] div_cnt;
      always_ff @(posedge clk) begin
        if (rst) begin
          div_cnt  <= '0;
          pix_en_q <= 1'b0;
        end else if (div_cnt == w_div'(div - 1)) begin
          div_cnt  <= '0;
          pix_en_q <= 1'b1;
        end else begin
          div_cnt  <= div_cnt + 1'b1;
          pix_en_q <= 1'b0;
        end
      end
    end
  endgenerate

  assign h_last = (hpos == w_x'(h_total - 1));
  assign v_last = (vpos == w_y'(v_total - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      hpos <= '0;
      vpos <= '0;
    end else if (pix_en_q) begin
      if (h_last) begin
        hpos <= '0;
        vpos <= v_last ? '0 : vpos + 1'b1;
      end else begin
        hpos <= hpos + 1'b1;
      end
    end
  end

  assign hpos_w = 32'(hpos);
  assign vpos_w = 32'(vpos);

  always_comb begin
    act0 = (hpos_w < h_active) && (vpos_w < v_active);
    hs0  = (hpos_w >= hs_lo) && (hpos_w < hs_hi);
    vs0  = (vpos_w >= vs_lo) && (vpos_w < vs_hi);
  end

  // Bayer 2x2 threshold scaled to the dropped LSBs, added with saturation.
  function automatic logic [w_color_out-1:0] dither(
    input logic [w_color_in-1:0] c,
    input logic                  x0,
    input logic                  y0
  );
    logic [1:0]            b;
    logic [w_color_in:0]   t;
    logic [w_color_in:0]   sum;
    logic [w_color_in-1:0] sat;
    case ({x0, y0})
      2'b00:   b = 2'd0;
      2'b10:   b = 2'd2;
      2'b01:   b = 2'd3;
      default: b = 2'd1;
    endcase
    t   = ((w_color_in + 1)'(b) << shift) >> 2;
    sum = {1'b0, c} + t;
    sat = sum[w_color_in] ? '1 : sum[w_color_in-1:0];
    return sat[w_color_in-1 -: w_color_out];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      hsync_q      <= sync_inv;
      vsync_q      <= sync_inv;
      display_on_q <= 1'b0;
      red_q        <= '0;
      green_q      <= '0;
      blue_q       <= '0;
    end else if (pix_en_q) begin
      hsync_q      <= hs0 ^ sync_inv;
      vsync_q      <= vs0 ^ sync_inv;
      display_on_q <= act0;
      red_q        <= act0 ? dither(bus.red_in,   hpos[0], vpos[0]) : '0;
      green_q      <= act0 ? dither(bus.green_in, hpos[0], vpos[0]) : '0;
      blue_q       <= act0 ? dither(bus.blue_in,  hpos[0], vpos[0]) : '0;
    end
  end

  assign bus.x              = hpos;
  assign bus.y              = vpos;
  assign bus.pixel_en       = pix_en_q;
  assign bus.frame_start    = pix_en_q && h_last && v_last;
  assign bus.vga_hsync      = hsync_q;
  assign bus.vga_vsync      = vsync_q;
  assign bus.vga_display_on = display_on_q;
  assign bus.vga_red        = red_q;
  assign bus.vga_green      = green_q;
  assign bus.vga_blue       = blue_q;

endmodule

// File: tb/tb_vga_timing_dither.sv
// Bench: default 640x480 4->1 instance and a tiny div=1, active-high, pass-through instance.
module tb_vga_timing_dither;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   rst_q;
  int   errors = 0;
  int   checks = 0;

  typedef struct {
    int hs;
    int vs;
    int de;
    int r;
    int g;
    int b;
  } exp_t;

  always #5 clk = ~clk;
  // Reset as the DUT saw it at the last rising edge.
  always @(posedge clk) rst_q <= rst;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] red_pat(input logic [1:0] yy);
    case (yy)
      2'd0:    return 4'd8;
      2'd1:    return 4'd15;
      2'd2:    return 4'd0;
      default: return 4'd4;
    endcase
  endfunction

  function automatic int dith(input int c, input int x0, input int y0, input int wo);
    int sh, b, s;
    sh = 4 - wo;
    if (x0 == 0 && y0 == 0)      b = 0;
    else if (x0 == 1 && y0 == 0) b = 2;
    else if (x0 == 0)            b = 3;
    else                         b = 1;
    s = c + ((b << sh) >> 2);
    if (s > 15) s = 15;
    return s >> sh;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : gen
    localparam int HA  = (g == 0) ? 640 : 8;
    localparam int HF  = (g == 0) ? 16  : 2;
    localparam int HS  = (g == 0) ? 96  : 3;
    localparam int HB  = (g == 0) ? 48  : 2;
    localparam int VA  = (g == 0) ? 480 : 6;
    localparam int VF  = (g == 0) ? 10  : 1;
    localparam int VS  = (g == 0) ? 2   : 2;
    localparam int VB  = (g == 0) ? 33  : 1;
    localparam int CLK = (g == 0) ? 50  : 25;
    localparam int SAH = (g == 0) ? 0   : 1;
    localparam int WO  = (g == 0) ? 1   : 4;
    localparam int HT  = HA + HF + HS + HB;
    localparam int VT  = VA + VF + VS + VB;
    localparam int DIV = CLK / 25;
    localparam int WX  = $clog2(HT);
    localparam int WY  = $clog2(VT);
    localparam int IDLE = (SAH != 0) ? 0 : 1;

    vga_timing_dither_if #(.w_x(WX), .w_y(WY), .w_color_in(4), .w_color_out(WO)) bus ();

    vga_timing_dither #(
      .clk_mhz(CLK), .pixel_mhz(25),
      .h_active(HA), .h_front(HF), .h_sync(HS), .h_back(HB),
      .v_active(VA), .v_front(VF), .v_sync(VS), .v_back(VB),
      .sync_active_high(SAH), .w_color_in(4), .w_color_out(WO),
      .w_x(WX), .w_y(WY)
    ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
    );

    assign bus.red_in   = red_pat(bus.y[1:0]);
    assign bus.green_in = 4'hA;
    assign bus.blue_in  = bus.x[3:0];

    int   mh, mv, gap, since_x0, since_fs;
    bit   in_rst, seen_x0, seen_fs;
    exp_t q[$];
    exp_t e, o;

    always @(negedge clk) begin
      if (rst_q) begin
        if (!in_rst) begin
          check($sformatf("g%0d rst x", g), int'(bus.x), 0);
          check($sformatf("g%0d rst y", g), int'(bus.y), 0);
          check($sformatf("g%0d rst pixel_en", g), int'(bus.pixel_en), 0);
          check($sformatf("g%0d rst frame_start", g), int'(bus.frame_start), 0);
          check($sformatf("g%0d rst display_on", g), int'(bus.vga_display_on), 0);
          check($sformatf("g%0d rst hsync", g), int'(bus.vga_hsync), IDLE);
          check($sformatf("g%0d rst vsync", g), int'(bus.vga_vsync), IDLE);
          check($sformatf("g%0d rst colour", g),
                int'(bus.vga_red) + int'(bus.vga_green) + int'(bus.vga_blue), 0);
        end
        in_rst = 1'b1;
        mh = 0; mv = 0; gap = 0;
        since_x0 = 0; since_fs = 0; seen_x0 = 1'b0; seen_fs = 1'b0;
        q.delete();
      end else begin
        in_rst = 1'b0;
        gap++;
        if (bus.pixel_en) begin
          check($sformatf("g%0d pixel_en spacing", g), gap, DIV);
          gap = 0;
          check($sformatf("g%0d x", g), int'(bus.x), mh);
          check($sformatf("g%0d y", g), int'(bus.y), mv);
          check($sformatf("g%0d frame_start", g), int'(bus.frame_start),
                int'(mh == HT - 1 && mv == VT - 1));
          since_x0++;
          if (bus.x == 0) begin
            if (seen_x0) check($sformatf("g%0d line period", g), since_x0, HT);
            seen_x0 = 1'b1; since_x0 = 0;
          end
          since_fs++;
          if (bus.frame_start) begin
            if (seen_fs) check($sformatf("g%0d frame period", g), since_fs, HT * VT);
            seen_fs = 1'b1; since_fs = 0;
          end
          if (q.size() != 0) begin
            o = q.pop_front();
            check($sformatf("g%0d hsync", g), int'(bus.vga_hsync), o.hs);
            check($sformatf("g%0d vsync", g), int'(bus.vga_vsync), o.vs);
            check($sformatf("g%0d display_on", g), int'(bus.vga_display_on), o.de);
            check($sformatf("g%0d red", g), int'(bus.vga_red), o.r);
            check($sformatf("g%0d green", g), int'(bus.vga_green), o.g);
            check($sformatf("g%0d blue", g), int'(bus.vga_blue), o.b);
          end
          e.de = int'(mh < HA && mv < VA);
          e.hs = int'(mh >= HA + HF && mh < HA + HF + HS) ^ IDLE;
          e.vs = int'(mv >= VA + VF && mv < VA + VF + VS) ^ IDLE;
          e.r  = e.de ? dith(int'(red_pat(2'(mv))), mh & 1, mv & 1, WO) : 0;
          e.g  = e.de ? dith(10, mh & 1, mv & 1, WO) : 0;
          e.b  = e.de ? dith(mh & 15, mh & 1, mv & 1, WO) : 0;
          q.push_back(e);
          if (mh == HT - 1) begin
            mh = 0;
            mv = (mv == VT - 1) ? 0 : mv + 1;
          end else begin
            mh++;
          end
        end else begin
          check($sformatf("g%0d frame_start idle", g), int'(bus.frame_start), 0);
          check($sformatf("g%0d x hold", g), int'(bus.x), mh);
          check($sformatf("g%0d y hold", g), int'(bus.y), mv);
        end
      end
    end
  end

  initial begin
    bit found;
    repeat (4) @(negedge clk);
    rst = 1'b0;

    // Run the default instance into line 2, then reset mid-line.
    found = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (gen[0].bus.x == 300 && gen[0].bus.y == 2) begin
        found = 1'b1;
        break;
      end
    end
    check("reach x300 y2", int'(found), 1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Five full lines so every red pattern row and several frames of gen[1] are covered.
    repeat (8400) @(negedge clk);
    check("g0 lines after reset", int'(gen[0].bus.y), 5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
